// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding data-memory access with byte/half/word lanes and writeback pulse.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state;
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [4:0]  rd_reg;
  logic        misalign_reg;

  logic        is_mem;
  logic [1:0]  size_in;
  logic [31:0] addr_fix;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        trap;

  assign ex_ready = (state == IDLE);
  assign misalign = misalign_reg;
  // Both op bits set is illegal and falls through as a plain writeback.
  assign is_mem   = mem_read ^ mem_write;

  always_comb begin
    size_in = SZ_WORD;
    if (funct3[1:0] == 2'b00)
      size_in = SZ_BYTE;
    else if (funct3[1:0] == 2'b01)
      size_in = SZ_HALF;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_mem && (((size_in == SZ_HALF) && alu_result[0]) ||
                           ((size_in == SZ_WORD) && (alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Without the trap, misaligned low bits are simply dropped.
  always_comb begin
    addr_fix = alu_result;
    if (size_in == SZ_HALF)
      addr_fix[0] = 1'b0;
    else if (size_in == SZ_WORD)
      addr_fix[1:0] = 2'b00;
  end

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = store_data;
    if (size_in == SZ_BYTE) begin
      be_in    = 4'b0001 << addr_fix[1:0];
      wdata_in = {4{store_data[7:0]}};
    end else if (size_in == SZ_HALF) begin
      be_in    = 4'b0011 << addr_fix[1:0];
      wdata_in = {2{store_data[15:0]}};
    end
  end

  assign shifted = dmem_rdata >> {addr_lo_reg, 3'b000};

  always_comb begin
    load_val = dmem_rdata;
    if (size_reg == SZ_BYTE)
      load_val = uns_reg ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (size_reg == SZ_HALF)
      load_val = uns_reg ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_lo_reg  <= 2'd0;
      size_reg     <= SZ_BYTE;
      uns_reg      <= 1'b0;
      rd_reg       <= 5'd0;
      misalign_reg <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_data  <= alu_result;
              wb_rd    <= rd;
            end else if (trap) begin
              wb_valid     <= 1'b1;
              wb_rd        <= 5'd0;
              misalign_reg <= 1'b1;
            end else begin
              addr_lo_reg <= addr_fix[1:0];
              size_reg    <= size_in;
              uns_reg     <= funct3[2];
              rd_reg      <= rd;
              dmem_req    <= 1'b1;
              dmem_we     <= mem_write;
              dmem_addr   <= {addr_fix[31:2], 2'b00};
              dmem_be     <= be_in;
              dmem_wdata  <= wdata_in;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // Request outputs are untouched here until the grant arrives.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= 5'd0;
              state    <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= load_val;
            wb_rd    <= rd_reg;
            state    <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: pass-through, loads, stores, alignment and reset abandonment.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .rd(rd), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rdn, input logic wrn, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdn_idx);
    ex_valid   = 1'b1;
    mem_read   = rdn;
    mem_write  = wrn;
    funct3     = f3;
    alu_result = addr;
    store_data = sdata;
    rd         = rdn_idx;
    tick();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Load with immediate grant and response one cycle after grant.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rdi, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue(1'b1, 1'b0, f3, addr, 32'd0, rdi);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_data"}, wb_data, exp_data);
    chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rdi});
    tick();
    $display("load %s addr=0x%08h wb_data=0x%08h", tag, addr, wb_data);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    issue(1'b0, 1'b1, f3, addr, sdata, 5'd9);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    tick();
    chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    $display("store %s addr=0x%08h be=%b wdata=0x%08h", tag, addr, exp_be, exp_wdata);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; alu_result = 32'd0; store_data = 32'd0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    tick();
    $display("reset done");

    // Pass-through, then back-to-back pass-through including the illegal both-set op.
    issue(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'd0, 5'd5);
    chk("pt_wbv", {31'd0, wb_valid}, 32'd1);
    chk("pt_data", wb_data, 32'h0000_1234);
    chk("pt_rd", {27'd0, wb_rd}, 32'd5);
    tick();
    chk("pt_pulse", {31'd0, wb_valid}, 32'd0);
    chk("pt_hold", wb_data, 32'h0000_1234);
    $display("pass-through rd=5 data=0x00001234");
    issue(1'b0, 1'b0, 3'b000, 32'h0000_000A, 32'd0, 5'd1);
    chk("b2b1_data", wb_data, 32'h0000_000A);
    issue(1'b1, 1'b1, 3'b000, 32'h0000_000B, 32'd0, 5'd2);
    chk("b2b2_wbv", {31'd0, wb_valid}, 32'd1);
    chk("b2b2_data", wb_data, 32'h0000_000B);
    chk("b2b2_noreq", {31'd0, dmem_req}, 32'd0);
    tick();
    $display("back-to-back pass-through done");

    // lb 0x103 with grant delayed three cycles; rvalid alongside grant must be ignored.
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7);
    chk("lb_busy", {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_hold_req", {31'd0, dmem_req}, 32'd1);
      chk("lb_hold_addr", dmem_addr, 32'h0000_0100);
      tick();
    end
    chk("lb_hold_addr4", dmem_addr, 32'h0000_0100);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("lb_early_rvalid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("lb_wait", {31'd0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_rd}, 32'd7);
    tick();
    chk("lb_pulse", {31'd0, wb_valid}, 32'd0);
    chk("lb_ready", {31'd0, ex_ready}, 32'd1);
    $display("load lb addr=0x00000103 wb_data=0x%08h", wb_data);

    do_load("lhu", 3'b101, 32'h0000_0102, 5'd3, 32'hBEEF_0000, 32'h0000_0100, 32'h0000_BEEF);
    do_load("lh",  3'b001, 32'h0000_0102, 5'd4, 32'hBEEF_0000, 32'h0000_0100, 32'hFFFF_BEEF);
    do_load("lbu", 3'b100, 32'h0000_0101, 5'd6, 32'h0000_8000, 32'h0000_0100, 32'h0000_0080);

    do_store("sb", 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
    do_store("sh", 3'b001, 32'h0000_0202, 32'h1234_CDEF, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF);
    do_store("sw", 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0000_0204, 4'b1111, 32'hDEAD_BEEF);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0302, 32'd0, 5'd8);
    chk("lw_mis_noreq", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_flag", {31'd0, misalign}, 32'd1);
    chk("lw_mis_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lw_mis_rd", {27'd0, wb_rd}, 32'd0);
    tick();
    chk("lw_mis_clear", {31'd0, misalign}, 32'd0);
    chk("lw_mis_ready", {31'd0, ex_ready}, 32'd1);
    $display("misaligned lw trapped");
`else
    do_load("lw_mis", 3'b010, 32'h0000_0302, 5'd8, 32'hCAFE_F00D, 32'h0000_0300, 32'hCAFE_F00D);
    chk("lw_mis_flag", {31'd0, misalign}, 32'd0);
`endif

    // Reset while waiting for the response; a late rvalid/gnt must not produce writeback.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd10);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rw_in_wait", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_async_ready", {31'd0, ex_ready}, 32'd1);
    chk("rw_async_wbdata", wb_data, 32'd0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    chk("rw_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("rw_no_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_ready", {31'd0, ex_ready}, 32'd1);
    $display("reset during wait abandoned access");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
